fetch_arbiter: RTL and testbench
================================

FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-002 if_req  in  1  fetch request; held with if_addr stable until if_valid.
REQ-003 if_addr  in  32  fetch address; if_flush  in  1  cancel current/pending fetch.
REQ-004 if_rdata  out  32  fetched word; if_valid  out  1  one-cycle fetch-done pulse; if_stall  out  1  drives IFWrite low.
REQ-005 d_req  in  1  data request; d_we  in  1  write enable; d_addr  in  32; d_wdata  in  32; all held stable until d_valid.
REQ-006 d_rdata  out  32  load data; d_valid  out  1  one-cycle data-done pulse; d_stall  out  1  data-side stall.
REQ-007 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  shared single-port memory request, all registered.
REQ-008 mem_rdata  in  32; mem_ready  in  1  one-cycle completion strobe, valid only while mem_req=1.

Function
REQ-009 States: IDLE, SERV_D, SERV_I, DROP_I; encoded in one state register.
REQ-010 IDLE grant order: data over fetch, subject to the fairness rule in REQ-011.
REQ-011 2-bit counter of consecutive data grants made while if_req=1; at 2, the next IDLE grant goes to a pending fetch; cleared on any fetch grant or when if_req=0.
REQ-012 Grant in IDLE: latch address/data/we into mem_* at the edge; mem_req=1 from the next cycle; go to SERV_D or SERV_I.
REQ-013 mem_req and mem_* stay constant from grant until the cycle mem_ready=1; mem_req=0 in the cycle after mem_ready.
REQ-014 SERV_D with mem_ready: next cycle d_valid=1 for exactly one cycle; go to IDLE.
REQ-015 d_rdata: loads capture mem_rdata; writes leave d_rdata unchanged.
REQ-016 SERV_I with mem_ready and no if_flush: next cycle if_valid=1 for one cycle, if_rdata=mem_rdata; go to IDLE.
REQ-017 Flush without mem_ready in SERV_I: go to DROP_I; same cycle as mem_ready: discard word, go to IDLE; neither case asserts if_valid.
REQ-018 DROP_I: hold mem_req until mem_ready, discard data, go to IDLE.
REQ-019 No grant in IDLE to a requester whose valid pulse is high that cycle (requester address not yet updated).
REQ-020 if_req with if_flush=1 in IDLE is not granted that cycle.
REQ-021 if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid (combinational from registered valids).
REQ-022 mem_ready outside SERV_D/SERV_I/DROP_I is ignored.
REQ-023 Minimum latency: request at cycle 0, mem_req at 1, mem_ready at 1 gives valid at 2; back-to-back grant no earlier than cycle 3 for the other requester.

Reset
REQ-024 reset: state IDLE, fairness counter 0, mem_req/mem_we/if_valid/d_valid 0, mem_addr/mem_wdata/if_rdata/d_rdata 0x0, effective next edge.
REQ-025 Reset during SERV_*/DROP_I abandons the transaction with no valid pulse; the memory stub sees mem_req=0 the cycle after reset is sampled.

Verification
REQ-026 if_req, if_addr=0x10, mem_ready one cycle after mem_req, rdata=0x00500093: mem_addr=0x10; if_valid at cycle 3 with if_rdata=0x00500093; if_stall=1 in cycles 0-2.
REQ-027 if_req and d_req (load, 0x80) together: data granted first with mem_addr=0x80; fetch granted after d_valid and one cycle later; if_stall held throughout.
REQ-028 d_req held for 3 loads while if_req pending: grant order D, D, I, D.
REQ-029 if_flush in SERV_I before mem_ready (mem_ready 4 cycles late): DROP_I, mem_req held until mem_ready, no if_valid; new fetch 0x20 then completes normally.
REQ-030 Store d_we=1, addr 0x40, wdata 0xDEADBEEF: mem_we=1, mem_wdata=0xDEADBEEF; d_valid pulses; d_rdata unchanged.
REQ-031 reset asserted in SERV_D: next cycle mem_req=0, state IDLE, no d_valid; all outputs 0.

Source files
------------

// File: rtl/fetch_arbiter_if.sv
// Core-side fetch/data request ports plus the shared single-port memory bus
// that the fetch arbiter multiplexes onto.
interface fetch_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // Core pipeline plus memory view.
  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/fetch_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory;
// data wins by default, a fetch is forced through after two data grants in a row.
module fetch_arbiter (
  input  logic           clk,
  input  logic           reset,
  fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_D = 2'd1,
    SERV_I = 2'd2,
    DROP_I = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] fair_cnt;

  logic d_elig;
  logic i_elig;
  logic grant_d;
  logic grant_i;
  logic d_done;
  logic i_done;
  logic mem_release;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      next_state = SERV_D;
        else if (grant_i) next_state = SERV_I;
      end
      SERV_D: begin
        if (bus.mem_ready) next_state = IDLE;
      end
      SERV_I: begin
        if (bus.mem_ready)     next_state = IDLE;
        else if (bus.if_flush) next_state = DROP_I;
      end
      DROP_I: begin
        if (bus.mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // A requester whose done pulse is high has not yet presented its next
  // address, so it is held off for that cycle.
  always_comb begin
    d_elig  = bus.d_req & ~bus.d_valid;
    i_elig  = bus.if_req & ~bus.if_valid & ~bus.if_flush;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if (i_elig && (fair_cnt == 2'd2 || !d_elig)) grant_i = 1'b1;
      else if (d_elig)                               grant_d = 1'b1;
    end
    d_done      = (state == SERV_D) && bus.mem_ready;
    i_done      = (state == SERV_I) && bus.mem_ready && !bus.if_flush;
    mem_release = (state != IDLE) && bus.mem_ready;
    bus.if_stall = bus.if_req & ~bus.if_valid;
    bus.d_stall  = bus.d_req & ~bus.d_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      fair_cnt      <= '0;
    end else begin
      bus.if_valid <= i_done;
      bus.d_valid  <= d_done;

      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.if_addr;
      end else if (mem_release) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
      end

      if (i_done)                 bus.if_rdata <= bus.mem_rdata;
      if (d_done && !bus.mem_we)  bus.d_rdata  <= bus.mem_rdata;

      // Counts data grants that overtook a waiting fetch; saturates at 2.
      if (!bus.if_req || grant_i)          fair_cnt <= '0;
      else if (grant_d && fair_cnt != 2'd2) fair_cnt <= fair_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter with a negedge memory stub of programmable latency.
module tb_fetch_arbiter;

  logic clk;
  logic reset;

  fetch_arbiter_if bus ();

  fetch_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned passed;
  int unsigned total;

  logic [31:0] mem [0:63];
  int unsigned mem_lat;
  logic        force_ready;
  int unsigned iv_cnt;
  int unsigned dv_cnt;
  logic [31:0] grant_log [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory stub: decides mem_ready mid-cycle so the DUT samples it at the next edge.
  initial begin
    int unsigned lat_cnt;
    logic        prev_req;
    logic        rdy;
    lat_cnt = 0;
    prev_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.if_valid === 1'b1) iv_cnt++;
      if (bus.d_valid === 1'b1)  dv_cnt++;
      if (bus.mem_req === 1'b1 && prev_req !== 1'b1) grant_log.push_back(bus.mem_addr);
      prev_req = bus.mem_req;
      if (bus.mem_req === 1'b1) begin
        rdy = (lat_cnt == mem_lat);
        lat_cnt++;
      end else begin
        rdy = 1'b0;
        lat_cnt = 0;
      end
      if (rdy) begin
        bus.mem_rdata = mem[bus.mem_addr[7:2]];
        if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      end else begin
        bus.mem_rdata = 32'hBAD0BAD0;
      end
      bus.mem_ready = rdy | force_ready;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", bus.mem_req); else passed++;
    total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus.mem_we); else passed++;
    total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else passed++;
    total++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0)
      $display("FAIL reset_valids got %b%b want 00", bus.if_valid, bus.d_valid); else passed++;
    total++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
      $display("FAIL reset_rdata got %h/%h want 0/0", bus.if_rdata, bus.d_rdata); else passed++;
    total++; if (bus.if_stall !== 1'b0 || bus.d_stall !== 1'b0)
      $display("FAIL reset_stalls got %b%b want 00", bus.if_stall, bus.d_stall); else passed++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch();
    mem_lat = 1;
    bus.if_addr = 32'h10;
    bus.if_req = 1'b1;
    #1;
    total++; if (bus.if_stall !== 1'b1) $display("FAIL fetch_stall_c0 got %b want 1", bus.if_stall); else passed++;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0)
      $display("FAIL fetch_mem_c1 got req=%b addr=%h we=%b want 1/00000010/0", bus.mem_req, bus.mem_addr, bus.mem_we); else passed++;
    total++; if (bus.if_stall !== 1'b1) $display("FAIL fetch_stall_c1 got %b want 1", bus.if_stall); else passed++;
    cyc();
    total++; if (bus.if_valid !== 1'b0 || bus.if_stall !== 1'b1 || bus.mem_req !== 1'b1)
      $display("FAIL fetch_c2 got valid=%b stall=%b req=%b want 0/1/1", bus.if_valid, bus.if_stall, bus.mem_req); else passed++;
    cyc();
    total++; if (bus.if_valid !== 1'b1) $display("FAIL fetch_valid_c3 got %b want 1", bus.if_valid); else passed++;
    total++; if (bus.if_rdata !== 32'h00500093) $display("FAIL fetch_rdata got %h want 00500093", bus.if_rdata); else passed++;
    total++; if (bus.mem_req !== 1'b0 || bus.if_stall !== 1'b0)
      $display("FAIL fetch_c3_idle got req=%b stall=%b want 0/0", bus.mem_req, bus.if_stall); else passed++;
    bus.if_req = 1'b0;
    cyc();
    total++; if (bus.if_valid !== 1'b0) $display("FAIL fetch_valid_pulse got %b want 0", bus.if_valid); else passed++;
  endtask

  task automatic test_stray_ready();
    int unsigned iv0;
    int unsigned dv0;
    iv0 = iv_cnt;
    dv0 = dv_cnt;
    force_ready = 1'b1;
    repeat (3) cyc();
    force_ready = 1'b0;
    cyc();
    cyc();
    total++; if (bus.mem_req !== 1'b0) $display("FAIL stray_mem_req got %b want 0", bus.mem_req); else passed++;
    total++; if (iv_cnt != iv0 || dv_cnt != dv0)
      $display("FAIL stray_valids got %0d/%0d want %0d/%0d", iv_cnt, dv_cnt, iv0, dv0); else passed++;
    total++; if (bus.if_rdata !== 32'h00500093) $display("FAIL stray_if_rdata got %h want 00500093", bus.if_rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    mem_lat = 0;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h80;
    bus.d_req = 1'b1;
    bus.if_addr = 32'h10;
    bus.if_req = 1'b1;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80)
      $display("FAIL b2b_data_first got req=%b addr=%h want 1/00000080", bus.mem_req, bus.mem_addr); else passed++;
    cyc();
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h10000020)
      $display("FAIL b2b_load got valid=%b rdata=%h want 1/10000020", bus.d_valid, bus.d_rdata); else passed++;
    total++; if (bus.mem_req !== 1'b0 || bus.if_stall !== 1'b1 || bus.d_stall !== 1'b0)
      $display("FAIL b2b_c2 got req=%b istall=%b dstall=%b want 0/1/0", bus.mem_req, bus.if_stall, bus.d_stall); else passed++;
    bus.d_req = 1'b0;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10)
      $display("FAIL b2b_fetch_grant got req=%b addr=%h want 1/00000010", bus.mem_req, bus.mem_addr); else passed++;
    total++; if (bus.if_stall !== 1'b1 || bus.d_valid !== 1'b0)
      $display("FAIL b2b_c3 got istall=%b dvalid=%b want 1/0", bus.if_stall, bus.d_valid); else passed++;
    cyc();
    total++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h00500093)
      $display("FAIL b2b_fetch_done got valid=%b rdata=%h want 1/00500093", bus.if_valid, bus.if_rdata); else passed++;
    bus.if_req = 1'b0;
    cyc();
  endtask

  task automatic test_fairness();
    logic [31:0] exp_order [4];
    exp_order = '{32'h84, 32'h88, 32'h20, 32'h8C};
    mem_lat = 0;
    grant_log.delete();
    bus.d_we = 1'b0;
    bus.d_addr = 32'h84;
    bus.d_req = 1'b1;
    bus.if_addr = 32'h20;
    bus.if_req = 1'b1;
    bus.if_flush = 1'b1;
    cyc();
    cyc();
    total++; if (bus.d_valid !== 1'b1) $display("FAIL fair_dvalid1 got %b want 1", bus.d_valid); else passed++;
    bus.d_addr = 32'h88;
    cyc();
    total++; if (bus.mem_req !== 1'b0) $display("FAIL fair_flush_blocks got req=%b want 0", bus.mem_req); else passed++;
    cyc();
    cyc();
    total++; if (bus.d_valid !== 1'b1) $display("FAIL fair_dvalid2 got %b want 1", bus.d_valid); else passed++;
    bus.d_addr = 32'h8C;
    cyc();
    bus.if_flush = 1'b0;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20)
      $display("FAIL fair_forced_fetch got req=%b addr=%h want 1/00000020", bus.mem_req, bus.mem_addr); else passed++;
    cyc();
    total++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h10000008)
      $display("FAIL fair_fetch_done got valid=%b rdata=%h want 1/10000008", bus.if_valid, bus.if_rdata); else passed++;
    bus.if_req = 1'b0;
    cyc();
    cyc();
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h10000023)
      $display("FAIL fair_load3 got valid=%b rdata=%h want 1/10000023", bus.d_valid, bus.d_rdata); else passed++;
    bus.d_req = 1'b0;
    cyc();
    total++; if (grant_log.size() != 4) $display("FAIL fair_grant_count got %0d want 4", grant_log.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) begin
        total++; if (grant_log[i] !== exp_order[i])
          $display("FAIL fair_order[%0d] got %h want %h", i, grant_log[i], exp_order[i]); else passed++;
      end
    end
  endtask

  task automatic test_flush_drop();
    int unsigned iv0;
    iv0 = iv_cnt;
    mem_lat = 4;
    bus.if_addr = 32'h30;
    bus.if_req = 1'b1;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h30)
      $display("FAIL drop_grant got req=%b addr=%h want 1/00000030", bus.mem_req, bus.mem_addr); else passed++;
    bus.if_flush = 1'b1;
    bus.if_req = 1'b0;
    cyc();
    bus.if_flush = 1'b0;
    cyc();
    bus.if_addr = 32'h20;
    bus.if_req = 1'b1;
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h30)
      $display("FAIL drop_hold_c3 got req=%b addr=%h want 1/00000030", bus.mem_req, bus.mem_addr); else passed++;
    cyc();
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h30)
      $display("FAIL drop_hold_c5 got req=%b addr=%h want 1/00000030", bus.mem_req, bus.mem_addr); else passed++;
    cyc();
    total++; if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0)
      $display("FAIL drop_release got req=%b valid=%b want 0/0", bus.mem_req, bus.if_valid); else passed++;
    mem_lat = 0;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20)
      $display("FAIL drop_new_fetch got req=%b addr=%h want 1/00000020", bus.mem_req, bus.mem_addr); else passed++;
    total++; if (iv_cnt != iv0) $display("FAIL drop_no_valid got %0d pulses want 0", iv_cnt - iv0); else passed++;
    cyc();
    total++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h10000008)
      $display("FAIL drop_refetch got valid=%b rdata=%h want 1/10000008", bus.if_valid, bus.if_rdata); else passed++;
    bus.if_req = 1'b0;
    cyc();
  endtask

  task automatic test_store();
    mem_lat = 1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h40;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_req = 1'b1;
    cyc();
    total++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEADBEEF)
      $display("FAIL store_mem got req=%b we=%b addr=%h wdata=%h want 1/1/00000040/deadbeef",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); else passed++;
    cyc();
    cyc();
    total++; if (bus.d_valid !== 1'b1 || bus.d_stall !== 1'b0)
      $display("FAIL store_done got valid=%b stall=%b want 1/0", bus.d_valid, bus.d_stall); else passed++;
    total++; if (bus.d_rdata !== 32'h10000023) $display("FAIL store_rdata_kept got %h want 10000023", bus.d_rdata); else passed++;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    cyc();
    total++; if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0)
      $display("FAIL store_pulse got valid=%b req=%b want 0/0", bus.d_valid, bus.mem_req); else passed++;
    bus.d_req = 1'b1;
    repeat (3) cyc();
    total++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF)
      $display("FAIL store_readback got valid=%b rdata=%h want 1/deadbeef", bus.d_valid, bus.d_rdata); else passed++;
    bus.d_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    int unsigned dv0;
    dv0 = dv_cnt;
    mem_lat = 4;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h44;
    bus.d_req = 1'b1;
    cyc();
    total++; if (bus.mem_req !== 1'b1) $display("FAIL rst_mid_grant got req=%b want 1", bus.mem_req); else passed++;
    cyc();
    reset = 1'b1;
    cyc();
    total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0)
      $display("FAIL rst_mid_mem got req=%b we=%b addr=%h wdata=%h want 0/0/0/0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); else passed++;
    total++; if (bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0)
      $display("FAIL rst_mid_outs got dv=%b iv=%b drd=%h ird=%h want 0/0/0/0",
               bus.d_valid, bus.if_valid, bus.d_rdata, bus.if_rdata); else passed++;
    reset = 1'b0;
    bus.d_req = 1'b0;
    repeat (6) cyc();
    total++; if (dv_cnt != dv0 || bus.mem_req !== 1'b0)
      $display("FAIL rst_mid_abandon got pulses=%0d req=%b want 0/0", dv_cnt - dv0, bus.mem_req); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    iv_cnt = 0;
    dv_cnt = 0;
    mem_lat = 1;
    force_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 + 32'(i);
    mem[4] = 32'h00500093;
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;

    test_reset();
    test_single_fetch();
    test_stray_ready();
    test_back_to_back();
    test_fairness();
    test_flush_drop();
    test_store();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
